vfb_sched: RTL

Frame-buffer scheduler for the video DMA path: arbitrates a single DDR3 command port between the camera-side write FIFO and the HDMI-side read FIFO. Manages a triple-buffered frame store in DDR so the writer and reader never touch the same frame. Sits between the FIFO/data-mover logic inside the video storage block and the DDR controller's user command port. All inputs are already synchronous to `clk`; CDC lives in the FIFOs.

---
 rtl/vfb_pkg.sv | 7 +
 rtl/vfb_bank_mgr.sv | 63 ++++++
 rtl/vfb_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/vfb_pkg.sv
// vfb_pkg: shared types and command encodings for the frame-buffer scheduler
package vfb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY} state_t;
  typedef logic [1:0] bank_t;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
endpackage

// File: rtl/vfb_bank_mgr.sv
// vfb_bank_mgr: triple-buffer bank rotation, frame status and deferred SOF handling
module vfb_bank_mgr
  import vfb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_idle,
  input  logic        i_wr_sof,
  input  logic        i_rd_sof,
  input  logic        i_wr_full,
  input  logic        i_wr_part,
  output logic        o_wr_ev,
  output logic        o_rd_ev,
  output logic [1:0]  o_wr_bank_nx,
  output logic [1:0]  o_rd_bank_nx,
  output logic [1:0]  o_wr_bank,
  output logic [1:0]  o_rd_bank,
  output logic        o_frame_valid,
  output logic [15:0] o_drop_cnt
);
  bank_t r_w, r_l, r_r;
  logic r_fresh, r_fv, r_wr_pend, r_rd_pend;
  logic [15:0] r_drop;
  bank_t w_w1, w_l1, w_l2, w_r2;
  logic w_swap_w, w_swap_r, w_f1;
  assign o_wr_ev = i_idle && (i_wr_sof || r_wr_pend);
  assign o_rd_ev = i_idle && (i_rd_sof || r_rd_pend);
  // writer swap resolves first so a simultaneous reader swap sees the new frame
  assign w_swap_w = o_wr_ev && i_wr_full;
  assign w_w1 = w_swap_w ? r_l : r_w;
  assign w_l1 = w_swap_w ? r_w : r_l;
  assign w_f1 = w_swap_w || r_fresh;
  assign w_swap_r = o_rd_ev && w_f1;
  assign w_r2 = w_swap_r ? w_l1 : r_r;
  assign w_l2 = w_swap_r ? r_r : w_l1;
  assign o_wr_bank_nx = w_w1;
  assign o_rd_bank_nx = w_r2;
  assign o_wr_bank = r_w;
  assign o_rd_bank = r_r;
  assign o_frame_valid = r_fv;
  assign o_drop_cnt = r_drop;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w <= 2'd0;
      r_l <= 2'd1;
      r_r <= 2'd2;
      r_fresh <= 1'b0;
      r_fv <= 1'b0;
      r_drop <= '0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      r_w <= w_w1;
      r_l <= w_l2;
      r_r <= w_r2;
      r_fresh <= w_f1 && !w_swap_r;
      r_fv <= r_fv || w_swap_w;
      if (o_wr_ev && !i_wr_full && i_wr_part && r_drop != 16'hffff) r_drop <= r_drop + 16'd1;
      r_wr_pend <= i_idle ? 1'b0 : (r_wr_pend || i_wr_sof);
      r_rd_pend <= i_idle ? 1'b0 : (r_rd_pend || i_rd_sof);
    end
  end
endmodule

// File: rtl/vfb_sched.sv
// vfb_sched: arbitrates one DDR command port between frame writer and reader
module vfb_sched
  import vfb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 29,
  parameter int unsigned FB_BASE      = 0,
  parameter int unsigned FB_STRIDE    = 'h0040_0000,
  parameter int unsigned FRAME_BURSTS = 3600,
  parameter int unsigned BURST_INC    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_sof,
  input  logic                  rd_sof,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  rd_urgent,
  output logic                  cmd_en,
  output logic [2:0]            cmd,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rdy,
  input  logic                  burst_done,
  output logic                  wr_ack,
  output logic                  wr_drop,
  output logic                  rd_ack,
  output logic [1:0]            wr_bank,
  output logic [1:0]            rd_bank,
  output logic                  frame_valid,
  output logic [15:0]           drop_cnt
);
  localparam int IW = $clog2(FRAME_BURSTS + 1);
  localparam logic [IW-1:0] FULL = IW'(FRAME_BURSTS);
  state_t r_state, w_state_nx;
  logic [IW-1:0] r_wr_idx, r_rd_idx, w_wr_idx_a, w_rd_idx_a;
  logic r_last_wr, r_wr_ack, r_rd_ack, r_wr_drop;
  logic [2:0] r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic w_idle, w_wr_ev, w_rd_ev, w_rd_el, w_g_rd, w_g_wr, w_drop, w_issue, w_hs;
  logic [1:0] w_wr_bank_nx, w_rd_bank_nx;
  assign w_idle = r_state == ST_IDLE;
  vfb_bank_mgr u_bank (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_idle        (w_idle),
    .i_wr_sof      (wr_sof),
    .i_rd_sof      (rd_sof),
    .i_wr_full     (r_wr_idx == FULL),
    .i_wr_part     (r_wr_idx != '0),
    .o_wr_ev       (w_wr_ev),
    .o_rd_ev       (w_rd_ev),
    .o_wr_bank_nx  (w_wr_bank_nx),
    .o_rd_bank_nx  (w_rd_bank_nx),
    .o_wr_bank     (wr_bank),
    .o_rd_bank     (rd_bank),
    .o_frame_valid (frame_valid),
    .o_drop_cnt    (drop_cnt)
  );
  // arbitration sees indices and banks as they stand after this cycle's SOFs
  assign w_wr_idx_a = w_wr_ev ? '0 : r_wr_idx;
  assign w_rd_idx_a = w_rd_ev ? '0 : r_rd_idx;
  assign w_rd_el = rd_req && (w_rd_idx_a < FULL);
  assign w_g_rd = w_idle && enable && w_rd_el && (rd_urgent || !wr_req || r_last_wr);
  assign w_g_wr = w_idle && enable && wr_req && !w_g_rd;
  assign w_drop = w_g_wr && (w_wr_idx_a == FULL);
  assign w_issue = w_g_rd || (w_g_wr && !w_drop);
  assign w_hs = (r_state == ST_ISSUE) && cmd_rdy;
  assign w_addr = ADDR_WIDTH'(FB_BASE)
                + ADDR_WIDTH'(w_g_rd ? w_rd_bank_nx : w_wr_bank_nx) * ADDR_WIDTH'(FB_STRIDE)
                + ADDR_WIDTH'(w_g_rd ? w_rd_idx_a : w_wr_idx_a) * ADDR_WIDTH'(BURST_INC);
  always_comb begin
    w_state_nx = r_state;
    cmd_en = r_state == ST_ISSUE;
    if (w_issue) w_state_nx = ST_ISSUE;
    if (w_hs) w_state_nx = ST_BUSY;
    if (r_state == ST_BUSY && burst_done) w_state_nx = ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_last_wr <= 1'b1;
      r_cmd <= CMD_WR;
      r_addr <= '0;
      r_wr_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wr_ack <= w_hs && r_cmd == CMD_WR;
      r_rd_ack <= w_hs && r_cmd == CMD_RD;
      r_wr_drop <= w_drop;
      if (w_idle) begin
        r_wr_idx <= w_wr_idx_a;
        r_rd_idx <= w_rd_idx_a;
      end
      if (w_hs && r_cmd == CMD_WR) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_hs && r_cmd == CMD_RD) r_rd_idx <= r_rd_idx + 1'b1;
      if (w_g_rd || w_g_wr) r_last_wr <= w_g_wr;
      if (w_issue) begin
        r_cmd <= w_g_rd ? CMD_RD : CMD_WR;
        r_addr <= w_addr;
      end
    end
  end
  assign cmd = r_cmd;
  assign cmd_addr = r_addr;
  assign wr_ack = r_wr_ack;
  assign rd_ack = r_rd_ack;
  assign wr_drop = r_wr_drop;
endmodule
